// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Byte-oriented asynchronous serial transmitter with 8N1-style
//                framing. Bytes are queued in a circular FIFO and shifted out
//                LSB-first on tx, one bit per bit_en tick from the upstream
//                fractional clock generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_en,
    input  logic [DATA_BITS-1:0]       data_in,
    input  logic                       we,
    output logic                       full,
    output logic [FIFO_DEPTH_BITS:0]   count,
    output logic                       busy,
    output logic                       tx
);

    localparam int c_DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int c_CNT_W = $clog2(DATA_BITS + 1);

    localparam logic [FIFO_DEPTH_BITS:0]   c_FULL_COUNT = (FIFO_DEPTH_BITS + 1)'(c_DEPTH);
    localparam logic [FIFO_DEPTH_BITS-1:0] c_PTR_ONE    = FIFO_DEPTH_BITS'(1);
    localparam logic [c_CNT_W-1:0]         c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]         c_LAST_BIT   = c_CNT_W'(DATA_BITS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DATA = 2'd1;
    localparam logic [1:0] c_ST_STOP = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;

    logic [DATA_BITS-1:0]       r_mem [0:c_DEPTH-1];
    logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   r_count;
    logic [FIFO_DEPTH_BITS:0]   w_count_next;
    logic                       r_full;

    logic [DATA_BITS-1:0]       r_shift;
    logic [c_CNT_W-1:0]         r_bit_cnt;
    logic                       r_tx;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_shift;
    logic                       w_tx_next;

    // A write is taken only when the registered full flag is clear, so a
    // write coinciding with a pop from a full FIFO is still dropped.
    assign w_push       = we & ~r_full;
    assign w_count_next = r_count
                        + (FIFO_DEPTH_BITS + 1)'(w_push)
                        - (FIFO_DEPTH_BITS + 1)'(w_pop);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: every transition is gated by the bit-rate tick
    always_comb begin
        w_state_next = r_state;
        if (bit_en) begin
            case (r_state)
                c_ST_IDLE: if (r_count != '0) w_state_next = c_ST_DATA;
                c_ST_DATA: if (r_bit_cnt == c_LAST_BIT) w_state_next = c_ST_STOP;
                c_ST_STOP: w_state_next = c_ST_IDLE;
                default:   w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // FSM outputs: pop/shift strobes and the next line level
    always_comb begin
        w_pop     = 1'b0;
        w_shift   = 1'b0;
        w_tx_next = r_tx;
        if (bit_en) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_count != '0) begin
                        w_pop     = 1'b1;
                        w_tx_next = 1'b0;
                    end else begin
                        w_tx_next = 1'b1;
                    end
                end
                c_ST_DATA: begin
                    w_shift   = 1'b1;
                    w_tx_next = r_shift[0];
                end
                c_ST_STOP: w_tx_next = 1'b1;
                default:   w_tx_next = 1'b1;
            endcase
        end
    end

    // FIFO storage; contents need no reset since pointers and count do
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL_COUNT);
        end
    end

    // Shift register, bit counter and registered line driver
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
            end
        end
    end

    assign tx    = r_tx;
    assign count = r_count;
    assign full  = r_full;
    assign busy  = (r_state != c_ST_IDLE) | (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx
//  Description : Self-checking bench for serial_tx. A frame-level reference
//                model (byte queue + pending-bit queue) predicts the line per
//                tick; a separate monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    localparam int DEPTH = 16;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       bit_en  = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       we      = 1'b0;
    logic       full;
    logic [4:0] count;
    logic       busy;
    logic       tx;

    int n_cmp = 0;
    int n_err = 0;
    int period = 0;
    int phase  = 0;

    // Reference model state
    byte unsigned m_fifo[$];
    bit           m_bits[$];
    bit           exp_q[$];
    bit           m_line = 1'b1;
    int           m_pre;
    byte unsigned m_byte;

    always #5 clk = ~clk;

    serial_tx #(
        .DATA_BITS       (8),
        .FIFO_DEPTH_BITS (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bit_en  (bit_en),
        .data_in (data_in),
        .we      (we),
        .full    (full),
        .count   (count),
        .busy    (busy),
        .tx      (tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is start bit, data LSB-first, stop bit.
    // Pops happen only when no frame bits are pending and the queue held data
    // before this edge; writes are accepted while the queue held < DEPTH.
    always @(posedge clk) begin
        if (reset) begin
            m_fifo.delete();
            m_bits.delete();
            m_line = 1'b1;
            exp_q.push_back(1'b1);
        end else begin
            m_pre = m_fifo.size();
            if (bit_en) begin
                if (m_bits.size() == 0 && m_pre > 0) begin
                    m_byte = m_fifo.pop_front();
                    m_bits.push_back(1'b0);
                    for (int i = 0; i < 8; i++) m_bits.push_back(m_byte[i]);
                    m_bits.push_back(1'b1);
                end
                if (m_bits.size() != 0) m_line = m_bits.pop_front();
                else                    m_line = 1'b1;
                exp_q.push_back(m_line);
            end
            if (we && m_pre < DEPTH) m_fifo.push_back(data_in);
        end
    end

    // Monitor: on every tick (or reset) the line is a DUT output event
    initial begin
        logic ev;
        forever begin
            @(posedge clk);
            ev = bit_en | reset;
            #2;
            if (ev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_tick: got %0b expected <none queued> at %0t", tx, $time);
                end else begin
                    check("tx_tick", {31'd0, tx}, {31'd0, exp_q.pop_front()});
                end
            end
            check("tx_line", {31'd0, tx},    {31'd0, m_line});
            check("count",   {27'd0, count}, m_fifo.size());
            check("full",    {31'd0, full},  {31'd0, (m_fifo.size() == DEPTH)});
            check("busy",    {31'd0, busy},  {31'd0, (m_bits.size() != 0 || m_fifo.size() != 0)});
        end
    end

    task automatic step_raw(input logic w, input logic [7:0] d, input logic en, input logic r);
        @(negedge clk);
        reset   = r;
        we      = w;
        data_in = d;
        bit_en  = en;
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        logic en;
        if (period == 0) begin
            en = 1'b0;
        end else begin
            en    = (phase == 0);
            phase = (phase + 1) % period;
        end
        step_raw(w, d, en, r);
    endtask

    task automatic set_period(input int p);
        period = p;
        phase  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((busy !== 1'b0 || m_fifo.size() != 0 || m_bits.size() != 0) && k < limit) begin
            step(1'b0, 8'h00, 1'b0);
            k++;
        end
        n_cmp++;
        if (k >= limit) begin
            n_err++;
            $display("FAIL drain: got busy=%0b after %0d cycles expected idle", busy, k);
        end
        idle(3);
    endtask

    initial begin
        // Reset
        repeat (3) step_raw(1'b0, 8'h00, 1'b0, 1'b1);
        set_period(4);
        idle(3);

        // Single byte, tick every 4 cycles
        step(1'b1, 8'hA5, 1'b0);
        drain(200);

        // Back-to-back frames
        set_period(3);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        drain(200);

        // Overflow: 17 writes with no ticks, 17th dropped
        set_period(0);
        for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
        idle(2);
        set_period(2);
        drain(600);

        // Write at the start-bit tick with a full FIFO, then one cycle later
        set_period(0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        idle(1);
        step_raw(1'b1, 8'hAA, 1'b1, 1'b0);
        step_raw(1'b1, 8'hBB, 1'b0, 1'b0);
        idle(2);
        set_period(2);
        drain(600);

        // Continuous tick
        set_period(1);
        step(1'b1, 8'h3C, 1'b0);
        drain(50);

        // Reset mid-frame with bytes queued
        set_period(2);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        idle(7);
        step(1'b0, 8'h00, 1'b1);
        idle(30);

        // Randomized traffic with varying tick rates and sparse resets
        for (int seg = 0; seg < 20; seg++) begin
            set_period(int'($urandom_range(0, 5)));
            for (int c = 0; c < 150; c++) begin
                step(($urandom_range(0, 2) == 0), 8'($urandom),
                     ($urandom_range(0, 199) == 0));
            end
        end
        set_period(1);
        drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
